// File: rtl/rsa_result_fifo.sv
// rsa_result_fifo: captures one RSA result per eoc rising edge into a FIFO drained by pop
module rsa_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             eoc,
  input  logic [WIDTH-1:0] rsa_c,
  input  logic             pop,
  input  logic             flush,
  input  logic             clr_flags,
  input  logic             irq_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  output logic             irq
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic eoc_q, push, do_pop, acc, ov_set, uf_set;
  always_comb begin
    empty = count == '0;
    full = count == CNT_W'(DEPTH);
    irq = irq_en & ~empty;
    rd_data = empty ? '0 : mem[rd_ptr];
    push = ena & eoc & ~eoc_q;
    do_pop = ena & pop & ~empty & ~flush;
    acc = push & ~flush & (~full | do_pop);
    ov_set = push & ~flush & full & ~do_pop;
    uf_set = ena & pop & empty & ~flush;
  end
  always_ff @(posedge clk)
    if (acc) mem[wr_ptr] <= rsa_c;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      eoc_q <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else if (ena) begin
      eoc_q <= eoc;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
      end else begin
        wr_ptr <= wr_ptr + AW'(acc);
        rd_ptr <= rd_ptr + AW'(do_pop);
        count <= count + CNT_W'(acc) - CNT_W'(do_pop);
        overflow <= ov_set | (overflow & ~clr_flags);
        underflow <= uf_set | (underflow & ~clr_flags);
      end
    end
  end
endmodule

// File: tb/tb_rsa_result_fifo.sv
// tb_rsa_result_fifo: directed stimulus against a queue model plus literal checkpoints
module tb_rsa_result_fifo;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, ena = 1, eoc = 0, pop = 0, flush = 0, clr_flags = 0, irq_en = 1;
  logic [7:0] rsa_c = 0, rd_data;
  logic [2:0] count;
  logic empty, full, overflow, underflow, irq;
  int passed = 0, total = 0;
  bit chk_on = 0;
  logic [7:0] q[$];
  bit meq = 0, mov = 0, muf = 0;
  rsa_result_fifo #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ena(ena), .eoc(eoc), .rsa_c(rsa_c), .pop(pop), .flush(flush),
    .clr_flags(clr_flags), .irq_en(irq_en), .rd_data(rd_data), .count(count), .empty(empty),
    .full(full), .overflow(overflow), .underflow(underflow), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
  endtask
  always @(posedge clk) begin
    bit pe, popped, ovs, ufs;
    if (rst) begin
      q.delete();
      meq = 0;
      mov = 0;
      muf = 0;
    end else if (ena) begin
      pe = eoc && !meq;
      meq = eoc;
      if (flush) q.delete();
      else begin
        ufs = pop && q.size() == 0;
        popped = pop && q.size() > 0;
        ovs = pe && q.size() == DEPTH && !popped;
        if (popped) void'(q.pop_front());
        if (pe && !ovs) q.push_back(rsa_c);
        mov = ovs || (mov && !clr_flags);
        muf = ufs || (muf && !clr_flags);
      end
    end
  end
  always @(negedge clk) if (chk_on) begin
    chk("m_rd_data", rd_data, q.size() ? q[0] : 8'h00);
    chk("m_count", count, q.size());
    chk("m_empty", empty, q.size() == 0);
    chk("m_full", full, q.size() == DEPTH);
    chk("m_overflow", overflow, mov);
    chk("m_underflow", underflow, muf);
    chk("m_irq", irq, irq_en && q.size() != 0);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse(input logic [7:0] c);
    rsa_c = c;
    eoc = 1;
    tick();
    eoc = 0;
    tick();
  endtask
  task automatic do_pop();
    pop = 1;
    tick();
    pop = 0;
  endtask
  initial begin
    logic [7:0] exp4 [4];
    tick();
    tick();
    rst = 0;
    chk_on = 1;
    chk("rst_count", count, 0);
    chk("rst_rd", rd_data, 0);
    chk("rst_empty", empty, 1);
    chk("rst_irq", irq, 0);
    rsa_c = 8'h5A;
    eoc = 1;
    tick();
    chk("cap_count", count, 1);
    chk("cap_rd", rd_data, 8'h5A);
    chk("cap_irq", irq, 1);
    repeat (10) tick();
    chk("hold_count", count, 1);
    eoc = 0;
    tick();
    do_pop();
    chk("drain_empty", empty, 1);
    pulse(8'h11);
    pulse(8'h22);
    pulse(8'h33);
    pulse(8'h44);
    chk("fill_full", full, 1);
    chk("fill_count", count, 4);
    pulse(8'h55);
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, 4);
    chk("ovf_head", rd_data, 8'h11);
    clr_flags = 1;
    tick();
    clr_flags = 0;
    chk("clr_ovf", overflow, 0);
    rsa_c = 8'h66;
    eoc = 1;
    pop = 1;
    tick();
    eoc = 0;
    pop = 0;
    chk("pp_count", count, 4);
    chk("pp_ovf", overflow, 0);
    chk("pp_head", rd_data, 8'h22);
    exp4 = '{8'h22, 8'h33, 8'h44, 8'h66};
    for (int i = 0; i < 4; i++) begin
      chk("pp_order", rd_data, exp4[i]);
      do_pop();
    end
    chk("pp_empty", empty, 1);
    chk("pp_rd0", rd_data, 0);
    chk("pp_irq0", irq, 0);
    rsa_c = 8'h77;
    eoc = 1;
    pop = 1;
    tick();
    eoc = 0;
    pop = 0;
    chk("ep_count", count, 1);
    chk("ep_uf", underflow, 1);
    chk("ep_rd", rd_data, 8'h77);
    clr_flags = 1;
    tick();
    clr_flags = 0;
    chk("clr_uf", underflow, 0);
    do_pop();
    pulse(8'h01);
    pulse(8'h02);
    pulse(8'h03);
    repeat (3) do_pop();
    for (int i = 0; i < 4; i++) pulse(8'hA0 + 8'(i));
    chk("wrap_full", full, 1);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_order", rd_data, 8'hA0 + 8'(i));
      do_pop();
    end
    pulse(8'h01);
    pulse(8'h02);
    pulse(8'h03);
    chk("pre_flush", count, 3);
    rsa_c = 8'h99;
    eoc = 1;
    flush = 1;
    tick();
    flush = 0;
    eoc = 0;
    chk("flush_count", count, 0);
    tick();
    chk("flush_nocap", count, 0);
    pulse(8'hB1);
    ena = 0;
    rsa_c = 8'hB2;
    eoc = 1;
    pop = 1;
    tick();
    tick();
    chk("ena_count", count, 1);
    chk("ena_rd", rd_data, 8'hB1);
    eoc = 0;
    pop = 0;
    ena = 1;
    tick();
    chk("ena_after", count, 1);
    do_pop();
    pop = 1;
    clr_flags = 1;
    tick();
    pop = 0;
    clr_flags = 0;
    chk("set_beats_clr", underflow, 1);
    pulse(8'hC1);
    pulse(8'hC2);
    chk("pre_rst", count, 2);
    rst = 1;
    tick();
    rst = 0;
    chk("rst2_count", count, 0);
    chk("rst2_rd", rd_data, 0);
    chk("rst2_uf", underflow, 0);
    chk("rst2_ovf", overflow, 0);
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
